// File: rtl/token_swirl_arbiter.sv
// Round-robin token arbiter: one-hot grant, request/hold handshake, one-cycle break-before-make gap.
// Optional hold timeout with lockout compiled in by defining TOKEN_SWIRL_TIMEOUT_EN.
module token_swirl_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic                 CLK,
  input  logic                 RB,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic                 BUSY,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 TIMEOUT
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   owner_q, owner_d;
  logic [W-1:0]   tok_q, tok_d;
  logic [N-1:0]   elig;
  logic           found;
  logic [W-1:0]   sel;

  function automatic logic [W-1:0] wrap_idx(
    input logic [W-1:0] base,
    input int           off
  );
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return W'(s);
  endfunction

`ifdef TOKEN_SWIRL_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [7:0]   cnt_q, cnt_d;
  logic [N-1:0] mask_q, mask_d;
  logic         timeout_q, timeout_d;

  assign elig    = REQ & ~mask_q;
  assign TIMEOUT = timeout_q;
`else
  logic unused_hold;

  assign unused_hold = (HOLD_MAX > 0);
  assign elig        = REQ;
  assign TIMEOUT     = 1'b0;
`endif

  // First eligible requester at or after the token, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = tok_q;
    for (int i = 0; i < N; i++) begin
      if (!found && elig[wrap_idx(tok_q, i)]) begin
        found = 1'b1;
        sel   = wrap_idx(tok_q, i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    tok_d   = tok_q;
`ifdef TOKEN_SWIRL_TIMEOUT_EN
    cnt_d     = cnt_q;
    mask_d    = mask_q & REQ;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          owner_d    = sel;
          state_d    = GRANT;
`ifdef TOKEN_SWIRL_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (!REQ[owner_q]) begin
          gnt_d   = '0;
          tok_d   = wrap_idx(owner_q, 1);
          state_d = GAP;
        end
`ifdef TOKEN_SWIRL_TIMEOUT_EN
        else if (cnt_q + 8'd1 == HOLD_LIM) begin
          gnt_d           = '0;
          tok_d           = wrap_idx(owner_q, 1);
          state_d         = GAP;
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = |gnt_d;
  end

  always_ff @(posedge CLK or negedge RB) begin
    if (!RB) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      owner_q   <= '0;
      tok_q     <= '0;
`ifdef TOKEN_SWIRL_TIMEOUT_EN
      cnt_q     <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      tok_q     <= tok_d;
`ifdef TOKEN_SWIRL_TIMEOUT_EN
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign GNT   = gnt_q;
  assign BUSY  = busy_q;
  assign OWNER = owner_q;

endmodule

// File: tb/tb_token_swirl_arbiter.sv
// Directed bench for token_swirl_arbiter: expected grant state queued per step,
// popped and asserted after each clock edge.
module tb_token_swirl_arbiter;

  logic       CLK = 1'b0;
  logic       RB  = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [3:0] GNT;
  logic       BUSY;
  logic [1:0] OWNER;
  logic       TIMEOUT;

  int total = 0;
  int bad   = 0;
  int tok_m;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  always #5 CLK = ~CLK;

  token_swirl_arbiter #(
    .N(4),
    .HOLD_MAX(4)
  ) dut (
    .CLK(CLK),
    .RB(RB),
    .REQ(REQ),
    .GNT(GNT),
    .BUSY(BUSY),
    .OWNER(OWNER),
    .TIMEOUT(TIMEOUT)
  );

  task automatic push(input logic [3:0] g, input logic [1:0] own,
                      input logic to, input string tag);
    exp_q.push_back({g, |g, own, to});
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    logic [7:0] e;
    logic [7:0] o;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {GNT, BUSY, OWNER, TIMEOUT};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: {gnt,busy,owner,to} got %b want %b", t, o, e);
    end
    total++;
    assert ($onehot0(GNT) === 1'b1) else begin
      bad++;
      $error("FAIL %s_onehot: gnt got %b want one-hot-or-zero", t, GNT);
    end
  endtask

  task automatic step(input logic [3:0] req, input logic [3:0] g,
                      input logic [1:0] own, input logic to,
                      input string tag);
    REQ = req;
    push(g, own, to, tag);
    @(posedge CLK);
    #1;
    chk();
  endtask

  initial begin
    #1 RB = 1'b0;
    #1;
    push(4'b0000, 2'd0, 1'b0, "reset");
    chk();
    @(posedge CLK);
    #1 RB = 1'b1;

    step(4'b0001, 4'b0001, 2'd0, 1'b0, "grant0");
    step(4'b0001, 4'b0001, 2'd0, 1'b0, "hold0");
    RB = 1'b0;
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst_async");
    chk();
    @(posedge CLK);
    #1;
    push(4'b0000, 2'd0, 1'b0, "rst_hold");
    chk();
    RB = 1'b1;
    step(4'b0001, 4'b0001, 2'd0, 1'b0, "rst_regrant");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "rel0");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "gap0");

    step(4'b0100, 4'b0100, 2'd2, 1'b0, "g2");
    step(4'b0100, 4'b0100, 2'd2, 1'b0, "hold2");
    step(4'b0100, 4'b0100, 2'd2, 1'b0, "hold2");
    step(4'b0000, 4'b0000, 2'd2, 1'b0, "rel2");
    step(4'b0000, 4'b0000, 2'd2, 1'b0, "gap2");

    step(4'b0101, 4'b0001, 2'd0, 1'b0, "wrap");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "wrap_rel");
    step(4'b0000, 4'b0000, 2'd0, 1'b0, "wrap_gap");

    tok_m = 1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << tok_m;
      step(4'b1111, oh, 2'(tok_m), 1'b0, "rr_gnt");
      step(4'b1111, oh, 2'(tok_m), 1'b0, "rr_hold");
      step(4'b1111, oh, 2'(tok_m), 1'b0, "rr_hold");
      step(4'b1111 & ~oh, 4'b0000, 2'(tok_m), 1'b0, "rr_rel");
      step(4'b1111, 4'b0000, 2'(tok_m), 1'b0, "rr_gap");
      tok_m = (tok_m + 1) % 4;
    end

    step(4'b0010, 4'b0010, 2'd1, 1'b0, "to_gnt");
`ifdef TOKEN_SWIRL_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      step(4'b1010, 4'b0010, 2'd1, 1'b0, "to_hold");
    step(4'b1010, 4'b0000, 2'd1, 1'b1, "timeout");
    step(4'b1010, 4'b0000, 2'd1, 1'b0, "to_gap");
    step(4'b1010, 4'b1000, 2'd3, 1'b0, "g3_after_to");
    step(4'b0010, 4'b0000, 2'd3, 1'b0, "rel3");
    step(4'b0010, 4'b0000, 2'd3, 1'b0, "gap3");
    step(4'b0010, 4'b0000, 2'd3, 1'b0, "locked1");
    step(4'b0000, 4'b0000, 2'd3, 1'b0, "drop1");
    step(4'b0010, 4'b0010, 2'd1, 1'b0, "regrant1");
`else
    for (int i = 0; i < 20; i++)
      step(4'b1010, 4'b0010, 2'd1, 1'b0, "hold_forever");
    step(4'b1000, 4'b0000, 2'd1, 1'b0, "rel1");
    step(4'b1000, 4'b0000, 2'd1, 1'b0, "gap1");
    step(4'b1000, 4'b1000, 2'd3, 1'b0, "g3_pending");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
